pll_lock_supervisor: RTL
========================

// Module: pll_lock_supervisor
// PURPOSE
//  Controller on the driving side of the PLL's rst/locked interface: pulses PLL reset, waits for lock with timeout,
//  qualifies lock stability, then releases N core resets in a staggered sequence. Runs on free-running refclk (50 MHz).
//  Lock loss re-asserts every core reset at once and restarts qualification. Outputs feed per-domain reset syncs.
// PARAMETERS
//  N_OUT          5          number of core reset outputs (one per PLL output clock domain)
//  RST_CYCLES     16         refclk cycles pll_rst is held high per PLL reset pulse (>=1)
//  LOCK_TIMEOUT   1000000    refclk cycles to wait for lock before re-pulsing pll_rst (20 ms)
//  STABLE_CYCLES  50000      consecutive synced-locked cycles required before release (1 ms)
//  STAGGER_CYCLES 16         refclk cycles between successive reset_out releases (>=1)
//  MAX_RETRIES    4          lock timeouts tolerated before FAULT (only with PLL_SUP_RETRY_LIMIT_EN)
// PORTS
//  refclk        in   1      reference clock; all logic on rising edge
//  rst           in   1      synchronous, active-high reset
//  locked        in   1      PLL lock, asynchronous to refclk
//  soft_reset    in   1      single-cycle request to re-run core reset sequence without resetting PLL
//  pll_rst       out  1      reset to PLL, active high
//  reset_out     out  N_OUT  core resets, active high; bit 0 released first
//  ready         out  1      all core resets released, PLL locked
//  relock_count  out  8      lock-loss events seen in RELEASE/RUN, saturates at 255
//  fault         out  1      retry limit exhausted (0 when feature compiled out)
//  state         out  3      current FSM encoding, debug only
// BEHAVIOUR
//  Reset values: pll_rst=1, reset_out=all 1, ready=0, relock_count=0, fault=0, state=PLL_RST. All outputs registered.
//  locked passes a 2-flop synchronizer -> locked_s (2 cycles latency); FSM uses only locked_s.
//  PLL_RST: pll_rst=1 for exactly RST_CYCLES cycles (first counted cycle = first cycle after rst low) -> WAIT_LOCK.
//  WAIT_LOCK: pll_rst=0; timer counts; locked_s=1 -> STABLE (counter cleared). Timer reaches LOCK_TIMEOUT
//   without lock -> PLL_RST, retry_cnt++.
//  STABLE: counts consecutive locked_s=1; locked_s=0 -> WAIT_LOCK (timer restarts from 0, no retry_cnt change);
//   count reaches STABLE_CYCLES -> RELEASE, retry_cnt cleared.
//  RELEASE: reset_out[0] clears on first RELEASE cycle; reset_out[i] clears STAGGER_CYCLES after reset_out[i-1].
//   Released bits stay 0. Cycle after reset_out[N_OUT-1] clears -> RUN, ready=1.
//  RUN: hold. Lock loss (locked_s=0) in RELEASE or RUN: next edge reset_out=all 1, ready=0, relock_count++
//   (saturating), -> WAIT_LOCK. pll_rst not pulsed on lock loss.
//  soft_reset in RELEASE/RUN: reset_out=all 1, ready=0 -> STABLE (full STABLE_CYCLES requalified). Ignored elsewhere.
//  Simultaneous lock loss and soft_reset: lock loss wins (relock_count increments).
//  Counters sized $clog2 of largest parameter; no wraparound possible before terminal compare.
//  rst at any time: immediate return to reset values on next edge, including mid-RELEASE.
// CONFIGURATION
//  `PLL_SUP_RETRY_LIMIT_EN defined: timeout when retry_cnt==MAX_RETRIES-1 -> FAULT state: pll_rst=1,
//   reset_out=all 1, ready=0, fault=1; left only by rst. Undefined: retries forever, fault tied 0, no FAULT state.
// STRUCTURE
//  Package pll_sup_pkg: state enum (PLL_RST=0, WAIT_LOCK=1, STABLE=2, RELEASE=3, RUN=4, FAULT=5), RELOCK_W=8.
//  Sub-module sync_2ff (parameter width) for locked; FSM, timers and release shifter in top module.
// TESTING (sim params: N_OUT=3, RST_CYCLES=4, LOCK_TIMEOUT=64, STABLE_CYCLES=16, STAGGER_CYCLES=4, MAX_RETRIES=2)
//  Power-up: locked held 1 -> pll_rst high 4 cycles after rst, reset_out 3'b111->110->100->000 at 4-cycle steps, ready=1.
//  No lock: locked=0 -> pll_rst re-pulsed every 4+64 cycles; with _EN, after 2nd timeout fault=1, pll_rst=1 held.
//  Glitch in STABLE: locked low 3 cycles at STABLE count 10 -> no release; full 16 cycles counted after relock.
//  Lock loss in RUN: locked low -> 3 cycles later reset_out=3'b111, ready=0, relock_count 0->1; re-release after 16+8.
//  Soft reset in RUN: soft_reset pulse -> reset_out=111 next cycle, pll_rst stays 0, re-release after 16 cycles.
//  Reset mid-RELEASE: rst when reset_out=3'b100 -> next edge all outputs at reset values, sequence restarts.

Source files
------------

// File: rtl/pll_sup_pkg.sv
// rtl/pll_sup_pkg.sv - shared state encoding and widths for the PLL lock supervisor
package pll_sup_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4,
        FAULT     = 3'd5
    } pll_sup_state_e;

    localparam int RELOCK_W = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for asynchronous level inputs
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // No reset: the chain settles within two edges of any input level.
    always_ff @(posedge clk_i) begin
        meta_q <= d_i;
        sync_q <= meta_q;
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - PLL reset/lock qualification and staggered core reset release
// Optional retry limit with FAULT state: define PLL_SUP_RETRY_LIMIT_EN.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int N_OUT          = 5,
    parameter int RST_CYCLES     = 16,
    parameter int LOCK_TIMEOUT   = 1000000,
    parameter int STABLE_CYCLES  = 50000,
    parameter int STAGGER_CYCLES = 16,
    parameter int MAX_RETRIES    = 4
) (
    input  logic                refclk,
    input  logic                rst,
    input  logic                locked,
    input  logic                soft_reset,
    output logic                pll_rst,
    output logic [N_OUT-1:0]    reset_out,
    output logic                ready,
    output logic [RELOCK_W-1:0] relock_count,
    output logic                fault,
    output logic [2:0]          state
);

    localparam int CNT_MAX = max_int(max_int(RST_CYCLES, LOCK_TIMEOUT),
                                     max_int(STABLE_CYCLES, STAGGER_CYCLES));
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST   = RETRY_W'(MAX_RETRIES - 1);

    pll_sup_state_e       state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [RETRY_W-1:0]   retry_cnt_q, retry_cnt_d;
    logic                 pll_rst_q, pll_rst_d;
    logic [N_OUT-1:0]     reset_out_q, reset_out_d;
    logic                 ready_q, ready_d;
    logic [RELOCK_W-1:0]  relock_q, relock_d;
    logic                 locked_s;
    logic                 lock_lost;
    logic                 stagger_tick;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk_i (refclk),
        .d_i   (locked),
        .q_o   (locked_s)
    );

    assign lock_lost    = ((state_q == RELEASE) || (state_q == RUN)) && !locked_s;
    assign stagger_tick = (state_q == RELEASE) && (cnt_q == STAGGER_LAST);

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q     <= PLL_RST;
            cnt_q       <= '0;
            retry_cnt_q <= '0;
            pll_rst_q   <= 1'b1;
            reset_out_q <= '1;
            ready_q     <= 1'b0;
            relock_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_cnt_q <= retry_cnt_d;
            pll_rst_q   <= pll_rst_d;
            reset_out_q <= reset_out_d;
            ready_q     <= ready_d;
            relock_q    <= relock_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        retry_cnt_d = retry_cnt_q;
        unique case (state_q)
            PLL_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    cnt_d = '0;
`ifdef PLL_SUP_RETRY_LIMIT_EN
                    if (retry_cnt_q == RETRY_LAST) begin
                        state_d = FAULT;
                    end else begin
                        state_d     = PLL_RST;
                        retry_cnt_d = retry_cnt_q + 1'b1;
                    end
`else
                    // Retries are unlimited; the count only saturates.
                    state_d = PLL_RST;
                    if (retry_cnt_q != RETRY_LAST) begin
                        retry_cnt_d = retry_cnt_q + 1'b1;
                    end
`endif
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d     = RELEASE;
                    cnt_d       = '0;
                    retry_cnt_d = '0;
                end
            end
            RELEASE, RUN: begin
                // Lock loss outranks a coincident soft reset.
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (soft_reset) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (state_q == RUN) begin
                    cnt_d = '0;
                end else if (reset_out_q == '0) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else if (stagger_tick) begin
                    cnt_d = '0;
                end
            end
            FAULT: begin
                cnt_d = '0;
            end
            default: begin
                state_d = PLL_RST;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        pll_rst_d   = (state_d == PLL_RST) || (state_d == FAULT);
        ready_d     = (state_d == RUN);
        reset_out_d = '1;
        relock_d    = relock_q;
        if (lock_lost && (relock_q != {RELOCK_W{1'b1}})) begin
            relock_d = relock_q + 1'b1;
        end
        if (state_d == RELEASE) begin
            if (state_q != RELEASE) begin
                reset_out_d = ~N_OUT'(1);
            end else if (stagger_tick) begin
                reset_out_d = reset_out_q << 1;
            end else begin
                reset_out_d = reset_out_q;
            end
        end else if (state_d == RUN) begin
            reset_out_d = '0;
        end
    end

    assign pll_rst      = pll_rst_q;
    assign reset_out    = reset_out_q;
    assign ready        = ready_q;
    assign relock_count = relock_q;
    assign state        = state_q;

`ifdef PLL_SUP_RETRY_LIMIT_EN
    logic fault_q;

    always_ff @(posedge refclk) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= (state_d == FAULT);
        end
    end

    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

endmodule
